// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered valid/ready ALU with shifts and an iterative shift-add multiply
// Defining ALU_SAT_EN adds signed saturating ADDS (1011) and SUBS (1100).
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int CNT_W   = SHAMT_W + 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
`ifdef ALU_SAT_EN
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             out_valid_q, out_valid_d;
  logic             zero_q, zero_d;
  logic             negative_q, negative_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             illegal_q, illegal_d;

  logic [WIDTH:0]   add_sum, sub_diff, inc_sum, dec_diff;
  logic             add_v, sub_v, inc_v, dec_v;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_ill;
  logic [SHAMT_W-1:0] shamt;

  logic             accept, load;
  logic [WIDTH-1:0] ld_res;
  logic             ld_c, ld_v, ld_ill;

  always_comb begin
    add_sum  = {1'b0, op1} + {1'b0, op2};
    sub_diff = {1'b0, op1} - {1'b0, op2};
    inc_sum  = {1'b0, op1} + {1'b0, ONE};
    dec_diff = {1'b0, op1} - {1'b0, ONE};
    add_v = (op1[WIDTH-1] == op2[WIDTH-1]) && (add_sum[WIDTH-1] != op1[WIDTH-1]);
    sub_v = (op1[WIDTH-1] != op2[WIDTH-1]) && (sub_diff[WIDTH-1] != op1[WIDTH-1]);
    inc_v = !op1[WIDTH-1] && inc_sum[WIDTH-1];
    dec_v = op1[WIDTH-1] && !dec_diff[WIDTH-1];
    shamt = op2[SHAMT_W-1:0];
  end

  // Single-cycle datapath; MUL is handled by the sequencer below.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (alu_control)
      4'b0000: alu_res = ~op1;
      4'b0001: alu_res = op1 & op2;
      4'b0010: alu_res = op1 ^ op2;
      4'b0011: alu_res = op1 | op2;
      4'b0100: begin alu_res = dec_diff[WIDTH-1:0]; alu_c = dec_diff[WIDTH]; alu_v = dec_v; end
      4'b0101: begin alu_res = add_sum[WIDTH-1:0];  alu_c = add_sum[WIDTH];  alu_v = add_v; end
      4'b0110: begin alu_res = sub_diff[WIDTH-1:0]; alu_c = sub_diff[WIDTH]; alu_v = sub_v; end
      4'b0111: begin alu_res = inc_sum[WIDTH-1:0];  alu_c = inc_sum[WIDTH];  alu_v = inc_v; end
      4'b1000: alu_res = '0;
      4'b1001: alu_res = op1 << shamt;
      4'b1010: alu_res = op1 >> shamt;
`ifdef ALU_SAT_EN
      // Overflow direction follows op1's sign for both add and subtract.
      4'b1011: begin
        alu_res = add_v ? (op1[WIDTH-1] ? MIN_NEG : MAX_POS) : add_sum[WIDTH-1:0];
        alu_c   = add_sum[WIDTH];
        alu_v   = add_v;
      end
      4'b1100: begin
        alu_res = sub_v ? (op1[WIDTH-1] ? MIN_NEG : MAX_POS) : sub_diff[WIDTH-1:0];
        alu_c   = sub_diff[WIDTH];
        alu_v   = sub_v;
      end
`endif
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    zero_d      = zero_q;
    negative_d  = negative_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    illegal_d   = illegal_q;
    load        = 1'b0;
    ld_res      = alu_res;
    ld_c        = alu_c;
    ld_v        = alu_v;
    ld_ill      = alu_ill;

    in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    accept   = in_valid && in_ready;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (alu_control == 4'b1000) begin
            mcand_d  = op1;
            mplier_d = op2;
            acc_d    = '0;
            cnt_d    = CNT_W'(WIDTH);
            state_d  = MUL;
          end else begin
            load = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          load    = 1'b1;
          ld_res  = acc_d;
          ld_c    = 1'b0;
          ld_v    = 1'b0;
          ld_ill  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      result_d    = ld_res;
      zero_d      = (ld_res == '0);
      negative_d  = ld_res[WIDTH-1];
      carry_d     = ld_c;
      overflow_d  = ld_v;
      illegal_d   = ld_ill;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      zero_q      <= zero_d;
      negative_q  <= negative_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign negative  = negative_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - table-driven and scoreboard bench for alu_pipe at WIDTH=32
module tb_alu_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] op1, op2, result;
  logic [3:0]  alu_control;
  logic        zero, negative, carry, overflow, illegal;

  alu_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .alu_control(alu_control),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .negative(negative), .carry(carry), .overflow(overflow), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic z, n, c, v, ill;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
    exp_t        e;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  exp_t got, want;
  vec_t tbl[$];

  function automatic exp_t mk(input logic [31:0] res, input logic z, n, c, v, ill);
    exp_t e;
    e.res = res; e.z = z; e.n = n; e.c = c; e.v = v; e.ill = ill;
    return e;
  endfunction

  // Reference model: wide integer arithmetic and range checks for overflow.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, b);
    exp_t   e;
    longint s;
    logic [63:0] p;
    e = '0;
    case (op)
      4'h0: e.res = ~a;
      4'h1: e.res = a & b;
      4'h2: e.res = a ^ b;
      4'h3: e.res = a | b;
      4'h4: begin e.res = a - 32'd1; e.c = (a == 32'd0); e.v = (a == 32'h8000_0000); end
      4'h5: begin
        s = longint'($signed(a)) + longint'($signed(b));
        e.res = a + b; e.c = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h6: begin
        s = longint'($signed(a)) - longint'($signed(b));
        e.res = a - b; e.c = (a < b);
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h7: begin e.res = a + 32'd1; e.c = (a == 32'hFFFF_FFFF); e.v = (a == 32'h7FFF_FFFF); end
      4'h8: begin p = {32'd0, a} * {32'd0, b}; e.res = p[31:0]; end
      4'h9: e.res = a << b[4:0];
      4'hA: e.res = a >> b[4:0];
      default: e.ill = 1'b1;
    endcase
    e.z = (e.res == 32'd0);
    e.n = e.res[31];
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] g, input logic [31:0] w);
    total++;
    if (g !== w) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, g, w);
    end
  endtask

  task automatic add_vec(input logic [3:0] op, input logic [31:0] a, b, input exp_t e);
    vec_t t;
    t.op = op; t.a = a; t.b = b; t.e = e;
    tbl.push_back(t);
  endtask

  task automatic send(input logic [3:0] op, input logic [31:0] a, b, input exp_t e);
    int t = 0;
    alu_control = op; op1 = a; op2 = b; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    else sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || out_valid) && t < 200) begin @(posedge clk); #1; t++; end
    chk("drain_queue", 32'(sb.size()), 32'd0);
  endtask

  task automatic run_mul(input logic [31:0] a, b, input exp_t e);
    int lat;
    alu_control = 4'h8; op1 = a; op2 = b; in_valid = 1'b1;
    @(negedge clk);
    chk("mul_accept", 32'(in_ready), 32'd1);
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 10) chk("mul_busy_in_ready", 32'(in_ready), 32'd0);
    end
    chk("mul_latency", 32'(lat), 32'd33);
  endtask

  // Scoreboard: outputs are sampled mid-cycle when a transfer will occur at the next edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got = {result, zero, negative, carry, overflow, illegal};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output got=%h want=none", got);
      end else begin
        want = sb.pop_front();
        if (got !== want) begin
          bad++;
          $display("FAIL result_flags got=%h want=%h", got, want);
        end
      end
    end
  end

  initial begin
    int seen;
    logic [3:0]  rop;
    logic [31:0] ra, rb;

    add_vec(4'h5, 32'hFFFF_FFFF, 32'h1,         mk(32'h0,         1, 0, 1, 0, 0));
    add_vec(4'h5, 32'h7FFF_FFFF, 32'h1,         mk(32'h8000_0000, 0, 1, 0, 1, 0));
    add_vec(4'h4, 32'h0,         32'h0,         mk(32'hFFFF_FFFF, 0, 1, 1, 0, 0));
    add_vec(4'h9, 32'h1,         32'd33,        mk(32'h2,         0, 0, 0, 0, 0));
    add_vec(4'h9, 32'h1,         32'd32,        mk(32'h1,         0, 0, 0, 0, 0));
    add_vec(4'hA, 32'h8000_0000, 32'd31,        mk(32'h1,         0, 0, 0, 0, 0));
    add_vec(4'hF, 32'hAAAA_AAAA, 32'h0,         mk(32'h0,         1, 0, 0, 0, 1));
    add_vec(4'hD, 32'h1234_5678, 32'h1,         mk(32'h0,         1, 0, 0, 0, 1));
    add_vec(4'h0, 32'h0,         32'h0,         mk(32'hFFFF_FFFF, 0, 1, 0, 0, 0));
    add_vec(4'h1, 32'hAAAA_5555, 32'hFFFF_0000, mk(32'hAAAA_0000, 0, 1, 0, 0, 0));
    add_vec(4'h2, 32'hF0F0_F0F0, 32'hFF00_FF00, mk(32'h0FF0_0FF0, 0, 0, 0, 0, 0));
    add_vec(4'h3, 32'h1234_0000, 32'h0000_5678, mk(32'h1234_5678, 0, 0, 0, 0, 0));
    add_vec(4'h6, 32'h5,         32'h7,         mk(32'hFFFF_FFFE, 0, 1, 1, 0, 0));
    add_vec(4'h6, 32'h8000_0000, 32'h1,         mk(32'h7FFF_FFFF, 0, 0, 0, 1, 0));
    add_vec(4'h7, 32'h7FFF_FFFF, 32'h0,         mk(32'h8000_0000, 0, 1, 0, 1, 0));
    add_vec(4'h8, 32'h3,         32'h5,         mk(32'hF,         0, 0, 0, 0, 0));
`ifdef ALU_SAT_EN
    add_vec(4'hB, 32'h7FFF_FFFF, 32'h10,        mk(32'h7FFF_FFFF, 0, 0, 0, 1, 0));
    add_vec(4'hC, 32'h8000_0000, 32'h1,         mk(32'h8000_0000, 0, 1, 0, 1, 0));
`else
    add_vec(4'hB, 32'h7FFF_FFFF, 32'h10,        mk(32'h0,         1, 0, 0, 0, 1));
    add_vec(4'hC, 32'h8000_0000, 32'h1,         mk(32'h0,         1, 0, 0, 0, 1));
`endif

    rst = 1'b1; in_valid = 1'b0; op1 = '0; op2 = '0; alu_control = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", 32'({zero, negative, carry, overflow, illegal}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (tbl[i]) send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e);
    drain();

    // Back-to-back single-cycle ops: one result per cycle, no bubble.
    @(posedge clk); #1;
    alu_control = 4'h5; op1 = 32'hFF; op2 = 32'h1; in_valid = 1'b1;
    sb.push_back(mk(32'h100, 0, 0, 0, 0, 0));
    @(negedge clk); chk("b2b_in_ready0", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    alu_control = 4'h6; op1 = 32'hFF; op2 = 32'h1;
    sb.push_back(mk(32'hFE, 0, 0, 0, 0, 0));
    @(negedge clk); chk("b2b_in_ready1", 32'(in_ready), 32'd1); chk("b2b_valid0", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    alu_control = 4'h7; op1 = 32'hFF; op2 = 32'h0;
    sb.push_back(mk(32'h100, 0, 0, 0, 0, 0));
    @(negedge clk); chk("b2b_in_ready2", 32'(in_ready), 32'd1); chk("b2b_valid1", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); chk("b2b_valid2", 32'(out_valid), 32'd1);
    drain();

    // Back-pressure: result held, input blocked, then release with a same-cycle accept.
    out_ready = 1'b0;
    send(4'h1, 32'hAAAA_5555, 32'hFFFF_0000, mk(32'hAAAA_0000, 0, 1, 0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_result", result, 32'hAAAA_0000);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1; alu_control = 4'h2; op1 = 32'h1; op2 = 32'h3; in_valid = 1'b1;
    @(negedge clk);
    chk("bp_release_accept", 32'(in_ready), 32'd1);
    sb.push_back(mk(32'h2, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); chk("bp_next_valid", 32'(out_valid), 32'd1);
    drain();

    run_mul(32'h0000_FFFF, 32'h0001_0001, mk(32'hFFFF_FFFF, 0, 1, 0, 0, 0));
    drain();
    run_mul(32'h1234_5678, 32'h0, mk(32'h0, 1, 0, 0, 0, 0));
    drain();

    // Reset ten cycles into a multiply: nothing may come out.
    @(posedge clk); #1;
    alu_control = 4'h8; op1 = 32'h0000_FFFF; op2 = 32'h0001_0001; in_valid = 1'b1;
    @(negedge clk); chk("rmul_accept", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rmul_out_valid_in_rst", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rmul_in_ready", 32'(in_ready), 32'd1);
    chk("rmul_result", result, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rmul_no_output", 32'(seen), 32'd0);

    // Random traffic against the reference model.
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      rop = 4'($urandom_range(0, 10));
      ra = $urandom;
      rb = $urandom;
      send(rop, ra, rb, model(rop, ra, rb));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Registered, parametrised successor to the team's 32-bit combinational ALU.
- Keeps the same 4-bit op encoding for the eight base ops and adds shifts and an iterative multi-cycle multiply.
- Adds a full status-flag set.
- Wraps everything in valid/ready handshakes on both input and output so it can sit between a decode stage and a writeback stage with back-pressure.

Parameters:
- WIDTH, 32: operand/result width, ≥4, power of two.
- SHAMT_W, $clog2(WIDTH): local, not overridable. Width of the shift amount taken from op2[SHAMT_W-1:0].

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands/opcode valid.
- in_ready  out  1  block can accept this cycle.
- op1  in  WIDTH  operand A.
- op2  in  WIDTH  operand B.
- alu_control  in  4  opcode.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- negative  out  1  result[WIDTH-1].
- carry  out  1  carry-out (ADD/INC), borrow (SUB/DEC).
- overflow  out  1  signed overflow (ADD/SUB/INC/DEC).
- illegal  out  1  opcode not implemented.

Behaviour:
- Reset (async, active-high): state=IDLE; out_valid=0; result=0; zero=0, negative=0, carry=0, overflow=0, illegal=0. Internal multiplier registers are cleared.
- Opcodes:
  - 0000 ~op1
  - 0001 op1&op2
  - 0010 op1^op2
  - 0011 op1|op2
  - 0100 op1-1
  - 0101 op1+op2
  - 0110 op1-op2
  - 0111 op1+1
  - 1000 MUL: low WIDTH bits of op1*op2, unsigned
  - 1001 SHL: op1 << op2[SHAMT_W-1:0]
  - 1010 SHR: logical, op1 >> op2[SHAMT_W-1:0]
  - Any other opcode: result=0, illegal=1.
- Arithmetic: computed at WIDTH+1 bits, wraps modulo 2^WIDTH.
  - carry = bit WIDTH of the sum. For SUB/DEC, carry=1 means borrow (op1 < subtrahend).
  - overflow follows two's-complement rules.
  - For logic, shift and MUL ops, carry=0 and overflow=0.
- zero and negative are always derived from the final registered result, including the illegal case (zero=1).
- Handshake:
  - Transfer on in_valid&in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Output holds result and all flags stable while out_valid&!out_ready.
  - out_valid drops the cycle after out_valid&out_ready unless a new single-cycle result is loaded on that same edge.
- FSM:
  - IDLE: on accept of a non-MUL op, register result and flags and set out_valid=1 on the next edge (latency 1, throughput 1/cycle). On accept of MUL, latch the operands, clear the accumulator, set the counter to WIDTH, go to MUL.
  - MUL: shift-add, one op2 bit per cycle, LSB first. Counter decrements each cycle. When the counter reaches 1, load result/flags, set out_valid=1 and go to IDLE. Latency is WIDTH+1 cycles from accept (33 at WIDTH=32). in_ready=0 throughout.
- Boundary cases:
  - Shift amount uses only the low SHAMT_W bits, e.g. SHL by 32 at WIDTH=32 equals shift by 0.
  - MUL with op2=0 still takes the full WIDTH cycles.
  - Simultaneous out_ready and a new accept in IDLE: the old result is consumed and the new one replaces it on the same edge, with no bubble.
  - rst asserted mid-MUL: aborts immediately, returns to IDLE with the reset values above, and no result is produced.
  - in_valid with in_ready=0: ignored. The source must hold its inputs.

Optional Feature:
- Macro: ALU_SAT_EN.
- Defined: opcodes 1011 ADDS and 1100 SUBS are implemented as signed saturating add/sub, 1-cycle latency.
  - On signed overflow, result clamps to 0x7FF..F (positive) or 0x800..0 (negative) and overflow=1.
  - carry is computed as for ADD/SUB.
- Undefined: 1011 and 1100 are illegal (result=0, illegal=1).

Test Plan:
- Reset mid-MUL:
  - Stimulus: WIDTH=32; accept MUL with op1=0x0000FFFF, op2=0x00010001.
  - Without reset: out_valid rises exactly 33 cycles after accept, result=0xFFFFFFFF.
  - Then repeat and assert rst at cycle 10: out_valid stays 0, in_ready=1 after release.
- Back-to-back throughput: ADD 0xFF+0x01 then SUB 0xFF-0x01 then INC 0xFF on consecutive cycles with out_ready=1 -> results 0x100, 0xFE, 0x100 on three consecutive cycles, in_ready never drops.
- Flags:
  - ADD 0xFFFFFFFF+1 -> result 0, zero=1, carry=1, overflow=0.
  - ADD 0x7FFFFFFF+1 -> 0x80000000, negative=1, overflow=1.
  - DEC 0 -> 0xFFFFFFFF, carry=1.
- Back-pressure: hold out_ready=0 after AND 0xAAAA5555&0xFFFF0000 -> result 0xAAAA0000 stable for 5 cycles, in_ready=0; raise out_ready -> transfer, next op accepted same cycle.
- Shifts and illegal:
  - SHL 0x1 by op2=33 -> 0x2.
  - SHR 0x80000000 by 31 -> 0x1.
  - Opcode 1111 with op1=0xAAAAAAAA -> result 0, zero=1, illegal=1.
- Saturation (ALU_SAT_EN only):
  - ADDS 0x7FFFFFFF+0x10 -> 0x7FFFFFFF, overflow=1.
  - SUBS 0x80000000-1 -> 0x80000000, overflow=1.
  - Without the macro, the same opcodes -> illegal=1.
